mem_io_responder: RTL

Target-side responder for the processor's single-port memory bus (mem_addr/mem_rdata/mem_rstrb/mem_wdata/mem_wmask). It contains a word-organised RAM with byte-lane writes and a small memory-mapped IO page. The IO page holds a LED register, an 8N1 UART transmitter and a cycle counter. It sits beside the core in the SoC top and answers every strobe with fixed 1-cycle read latency and no wait states.

---
 rtl/mem_io_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Memory-bus responder: word RAM with byte-lane writes plus an IO page (LEDs, 8N1 UART TX, cycle counter).
// Optional feature macro IO_CYCLES_EN: when defined, a free-running CYCLES counter is readable at IO offset 3.
module mem_io_responder #(
    parameter int MEM_WORDS = 1536,
    parameter int IO_BIT    = 22,
    parameter int BAUD_DIV  = 868,
    parameter int LED_W     = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      mem_addr,
    output logic [31:0]      mem_rdata,
    input  logic             mem_rstrb,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx,
    output logic             uart_busy
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} uart_state_e;

    logic [31:0]      ram_q [MEM_WORDS];
    logic [31:0]      rdata_q;
    logic [LED_W-1:0] leds_q;
    uart_state_e      state_q;
    logic [9:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [BW-1:0]    baud_cnt_q;
    logic             tx_q, busy_q, overrun_q;

    logic [29:0]      word_idx_s;
    logic [AW-1:0]    ram_idx_s;
    logic [1:0]       io_off_s;
    logic             io_sel_s, ram_ok_s, any_wr_s, ram_wr_s, uart_wr_s, stat_rd_s;
    logic [31:0]      rd_val_s, cycles_s;
    logic             unused_s;

    assign word_idx_s = mem_addr[31:2];
    assign ram_idx_s  = word_idx_s[AW-1:0];
    assign io_off_s   = mem_addr[3:2];
    assign io_sel_s   = mem_addr[IO_BIT];
    assign ram_ok_s   = !io_sel_s && (word_idx_s < 30'(MEM_WORDS));
    assign any_wr_s   = (mem_wmask != 4'b0000);
    assign ram_wr_s   = any_wr_s && ram_ok_s;
    assign uart_wr_s  = any_wr_s && io_sel_s && (io_off_s == 2'd1);
    assign stat_rd_s  = mem_rstrb && io_sel_s && (io_off_s == 2'd2);
    assign unused_s   = &{1'b0, mem_addr[1:0]};

`ifdef IO_CYCLES_EN
    logic [31:0] cycles_q;

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end
    assign cycles_s = cycles_q;
`else
    assign cycles_s = 32'd0;
`endif

    // Read-value mux; out-of-range RAM and write-only registers read as zero.
    always_comb begin
        rd_val_s = 32'd0;
        if (io_sel_s) begin
            case (io_off_s)
                2'd0:    rd_val_s = 32'(leds_q);
                2'd1:    rd_val_s = 32'd0;
                2'd2:    rd_val_s = {30'd0, overrun_q, busy_q};
                2'd3:    rd_val_s = cycles_s;
                default: rd_val_s = 32'd0;
            endcase
        end else if (ram_ok_s) begin
            rd_val_s = ram_q[ram_idx_s];
        end else begin
            rd_val_s = 32'd0;
        end
    end

    // RAM array is deliberately not reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    ram_q[ram_idx_s][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register and LED register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'd0;
            leds_q  <= '0;
        end else begin
            if (mem_rstrb) begin
                rdata_q <= rd_val_s;
            end
            if (any_wr_s && io_sel_s && (io_off_s == 2'd0)) begin
                leds_q <= mem_wdata[LED_W-1:0];
            end
        end
    end

    // Overrun flag: a dropped write sets it, a status read clears it after capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q <= 1'b0;
        end else if (uart_wr_s && (state_q == ST_SHIFT)) begin
            overrun_q <= 1'b1;
        end else if (stat_rd_s) begin
            overrun_q <= 1'b0;
        end
    end

    // UART transmitter FSM; a write on the final bit-period edge still sees SHIFT and is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shift_q    <= 10'h3FF;
            bit_cnt_q  <= 4'd0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (uart_wr_s) begin
                        shift_q    <= {1'b1, mem_wdata[7:0], 1'b0};
                        bit_cnt_q  <= 4'd0;
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            shift_q   <= {1'b1, shift_q[9:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_q;
    assign leds      = leds_q;
    assign uart_tx   = tx_q;
    assign uart_busy = busy_q;
endmodule
